// File: rtl/out_pingpong_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_pingpong_if
//  Description : Bundle of the upstream push, two-bank matrix memory and
//                downstream drain signals of the ping-pong output stage.
//                master = the output stage, slave = its surroundings.
//  Revision    : 1.0  initial release
// ============================================================================
interface out_pingpong_if #(
  parameter int DW = 64,
  parameter int CW = 3
) ();
  // upstream
  logic          pushin;
  logic          firstin;
  logic [DW-1:0] din;
  logic          stopin;
  // matrix memory write port
  logic          mwr;
  logic          mwbank;
  logic [CW-1:0] mwx;
  logic [CW-1:0] mwy;
  logic [DW-1:0] mwd;
  // matrix memory read port
  logic          mrbank;
  logic [CW-1:0] mrx;
  logic [CW-1:0] mry;
  logic [DW-1:0] mrd;
  // downstream
  logic [DW-1:0] dout;
  logic          pushout;
  logic          firstout;
  logic          lastout;
  logic          stopout;

  modport master (
    input  pushin, firstin, din, mrd, stopout,
    output stopin, mwr, mwbank, mwx, mwy, mwd,
    output mrbank, mrx, mry, dout, pushout, firstout, lastout
  );

  modport slave (
    output pushin, firstin, din, mrd, stopout,
    input  stopin, mwr, mwbank, mwx, mwy, mwd,
    input  mrbank, mrx, mry, dout, pushout, firstout, lastout
  );
endinterface
`default_nettype wire

// File: rtl/out_pingpong.sv
`default_nettype none
// ============================================================================
//  Module      : out_pingpong
//  Description : DIM x DIM matrix output stage with ping-pong banking in an
//                external two-bank memory. One bank fills while the other
//                drains; stopin only rises when both banks hold matrices.
//                Optional macro OUT_PINGPONG_TRANSPOSE_EN adds a transpose
//                input giving column-major readout.
//  Revision    : 1.0  initial release
// ============================================================================
module out_pingpong #(
  parameter int DW  = 64,
  parameter int DIM = 5,
  parameter int CW  = 3
) (
  input wire clk,
  input wire rst,
`ifdef OUT_PINGPONG_TRANSPOSE_EN
  input wire transpose,
`endif
  out_pingpong_if.master bus
);

  localparam logic [CW-1:0] c_last = CW'(DIM - 1);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FILL  = 2'd1;
  localparam logic [1:0] W_WAIT  = 2'd2;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  // ---------------- write side state ----------------
  logic [1:0]    r_wstate, w_wstate_nxt;
  logic          r_wbank;
  logic          r_stopin;
  logic          r_mwr, r_mwbank;
  logic [CW-1:0] r_mwx, r_mwy;
  logic [DW-1:0] r_mwd;
  logic [1:0]    r_full;

  logic          w_wacc, w_wlast, w_other_free, w_wtoggle, w_stopin_nxt;
  logic [CW-1:0] w_wx, w_wy;
  logic [1:0]    w_set_full, w_clr_full;

  // ---------------- read side state ----------------
  logic [0:0]    r_rstate, w_rstate_nxt;
  logic          r_rbank;
  logic [CW-1:0] r_mrx, r_mry;
  logic          r_pushout, r_firstout, r_lastout;

  logic          w_rstart, w_racc, w_rfree, w_tr;
  logic [CW-1:0] w_ax, w_ay;
  logic [CW-1:0] w_rx_nxt, w_ry_nxt;
  logic          w_push_nxt, w_first_nxt, w_last_nxt, w_rbank_nxt;

  // The read side releases its bank on acceptance of the final element.
  assign w_racc  = r_pushout & ~bus.stopout;
  assign w_rfree = (r_rstate == R_DRAIN) & w_racc & r_lastout;

  // Write acceptance and raster coordinate of the element being written.
  always_comb begin
    w_wacc = 1'b0;
    case (r_wstate)
      W_IDLE:  w_wacc = bus.pushin & bus.firstin;
      W_FILL:  w_wacc = bus.pushin;
      default: w_wacc = 1'b0;
    endcase
    w_wx = r_mwx;
    w_wy = r_mwy;
    if (bus.firstin) begin
      w_wx = '0;
      w_wy = '0;
    end else if (r_mwx == c_last) begin
      w_wx = '0;
      w_wy = r_mwy + 1'b1;
    end else begin
      w_wx = r_mwx + 1'b1;
    end
    w_wlast      = w_wacc & (w_wx == c_last) & (w_wy == c_last);
    // The other bank counts as free if it is empty or is being released now.
    w_other_free = ~r_full[~r_wbank] | (w_rfree & (r_rbank == ~r_wbank));
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wstate_nxt;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wacc)  w_wstate_nxt = W_FILL;
      W_FILL:  if (w_wlast) w_wstate_nxt = w_other_free ? W_IDLE : W_WAIT;
      W_WAIT:  if (w_rfree) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs: bank toggle, stall request and full-flag updates.
  always_comb begin
    w_wtoggle    = 1'b0;
    w_stopin_nxt = (w_wstate_nxt == W_WAIT);
    w_set_full   = 2'b00;
    w_clr_full   = 2'b00;
    case (r_wstate)
      W_FILL:  w_wtoggle = w_wlast & w_other_free;
      W_WAIT:  w_wtoggle = w_rfree;
      default: w_wtoggle = 1'b0;
    endcase
    if (w_wlast) w_set_full[r_wbank] = 1'b1;
    if (w_rfree) w_clr_full[r_rbank] = 1'b1;
  end

  // Registered memory write port, write bank pointer and stopin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mwr    <= 1'b0;
      r_mwbank <= 1'b0;
      r_mwx    <= '0;
      r_mwy    <= '0;
      r_mwd    <= '0;
      r_wbank  <= 1'b0;
      r_stopin <= 1'b0;
    end else begin
      r_mwr <= w_wacc;
      r_mwd <= bus.din;
      if (w_wacc) begin
        // mwbank captures the bank before any toggle on the final write.
        r_mwbank <= r_wbank;
        r_mwx    <= w_wx;
        r_mwy    <= w_wy;
      end
      if (w_wtoggle) r_wbank <= ~r_wbank;
      r_stopin <= w_stopin_nxt;
    end
  end

  // Bank occupancy; set and clear never target the same bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_full <= 2'b00;
    else      r_full <= (r_full | w_set_full) & ~w_clr_full;
  end

  // ---------------- read side ----------------
  assign w_rstart = (r_rstate == R_IDLE) & r_full[r_rbank];

`ifdef OUT_PINGPONG_TRANSPOSE_EN
  logic r_tr;
  // Readout order is latched at matrix start and held until the last element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_tr <= 1'b0;
    else if (w_rstart) r_tr <= transpose;
  end
  assign w_tr = r_tr;
`else
  assign w_tr = 1'b0;
`endif

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rstate <= R_IDLE;
    else      r_rstate <= w_rstate_nxt;
  end

  // Read FSM next-state logic.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (r_full[r_rbank])      w_rstate_nxt = R_DRAIN;
      R_DRAIN: if (w_racc && r_lastout)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs: next read coordinate and downstream flags.
  always_comb begin
    w_ax = r_mrx;
    w_ay = r_mry;
    if (w_tr) begin
      if (r_mry == c_last) begin
        w_ay = '0;
        w_ax = r_mrx + 1'b1;
      end else begin
        w_ay = r_mry + 1'b1;
      end
    end else begin
      if (r_mrx == c_last) begin
        w_ax = '0;
        w_ay = r_mry + 1'b1;
      end else begin
        w_ax = r_mrx + 1'b1;
      end
    end
    w_rx_nxt    = r_mrx;
    w_ry_nxt    = r_mry;
    w_push_nxt  = r_pushout;
    w_first_nxt = r_firstout;
    w_last_nxt  = r_lastout;
    w_rbank_nxt = r_rbank;
    if (w_rstart) begin
      w_rx_nxt    = '0;
      w_ry_nxt    = '0;
      w_push_nxt  = 1'b1;
      w_first_nxt = 1'b1;
      w_last_nxt  = 1'b0;
    end else if (w_racc) begin
      w_first_nxt = 1'b0;
      if (r_lastout) begin
        w_push_nxt  = 1'b0;
        w_last_nxt  = 1'b0;
        w_rbank_nxt = ~r_rbank;
      end else begin
        w_rx_nxt   = w_ax;
        w_ry_nxt   = w_ay;
        w_last_nxt = (w_ax == c_last) & (w_ay == c_last);
      end
    end
  end

  // Registered read address and downstream flags; all hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mrx      <= '0;
      r_mry      <= '0;
      r_pushout  <= 1'b0;
      r_firstout <= 1'b0;
      r_lastout  <= 1'b0;
      r_rbank    <= 1'b0;
    end else begin
      r_mrx      <= w_rx_nxt;
      r_mry      <= w_ry_nxt;
      r_pushout  <= w_push_nxt;
      r_firstout <= w_first_nxt;
      r_lastout  <= w_last_nxt;
      r_rbank    <= w_rbank_nxt;
    end
  end

  assign bus.stopin   = r_stopin;
  assign bus.mwr      = r_mwr;
  assign bus.mwbank   = r_mwbank;
  assign bus.mwx      = r_mwx;
  assign bus.mwy      = r_mwy;
  assign bus.mwd      = r_mwd;
  assign bus.mrbank   = r_rbank;
  assign bus.mrx      = r_mrx;
  assign bus.mry      = r_mry;
  assign bus.dout     = bus.mrd;
  assign bus.pushout  = r_pushout;
  assign bus.firstout = r_firstout;
  assign bus.lastout  = r_lastout;

endmodule
`default_nettype wire

// File: tb/tb_out_pingpong.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_pingpong
//  Description : Self-checking bench for out_pingpong with a two-bank
//                memory model, output scoreboard and a directed drain table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_out_pingpong;
  localparam int DW  = 64;
  localparam int DIM = 5;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  out_pingpong_if #(.DW(DW), .CW(CW)) bus ();
`ifdef OUT_PINGPONG_TRANSPOSE_EN
  logic transpose;
`endif

  out_pingpong #(.DW(DW), .DIM(DIM), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef OUT_PINGPONG_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .bus       (bus)
  );

  // two-bank matrix memory, combinational read
  logic [DW-1:0] mem [2][8][8];
  always @(posedge clk) if (bus.mwr) mem[bus.mwbank][bus.mwy][bus.mwx] <= bus.mwd;
  assign bus.mrd = mem[bus.mrbank][bus.mry][bus.mrx];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic first; logic last; logic [DW-1:0] d; } out_t;
  typedef struct packed { logic bank; logic [CW-1:0] y; logic [CW-1:0] x; logic [DW-1:0] d; } wr_t;
  out_t out_q[$];
  wr_t  w_q[$];
  out_t mon_o;
  wr_t  mon_w;
  logic stopin_seen;

  // monitor on the falling edge: accepted outputs, memory writes, stopin
  always @(negedge clk) begin
    if (rst) begin
      if (bus.pushout && !bus.stopout) begin
        mon_o.first = bus.firstout;
        mon_o.last  = bus.lastout;
        mon_o.d     = bus.dout;
        out_q.push_back(mon_o);
      end
      if (bus.mwr) begin
        mon_w.bank = bus.mwbank;
        mon_w.y    = bus.mwy;
        mon_w.x    = bus.mwx;
        mon_w.d    = bus.mwd;
        w_q.push_back(mon_w);
      end
      if (bus.stopin) stopin_seen = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mat(input int base, input int n, input bit first_on_first);
    for (int i = 0; i < n; i++) begin
      bus.pushin  = 1'b1;
      bus.firstin = first_on_first && (i == 0);
      bus.din     = DW'(base + i);
      cyc();
    end
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
  endtask

  // waits for 25 accepted elements and compares them to the expected matrix
  task automatic check_out(input string name, input int base, input bit tr);
    int   waited;
    int   idx;
    out_t o;
    waited = 0;
    while (out_q.size() < DIM * DIM && waited < 400) begin
      cyc();
      waited++;
    end
    if (out_q.size() < DIM * DIM) begin
      chk({name, " timeout, element count"}, 64'(out_q.size()), 64'(DIM * DIM));
    end else begin
      for (int i = 0; i < DIM * DIM; i++) begin
        idx = tr ? (i % DIM) * DIM + i / DIM : i;
        o = out_q.pop_front();
        chk($sformatf("%s data[%0d]", name, i), o.d, 64'(base + idx));
        chk($sformatf("%s first/last[%0d]", name, i), {62'd0, o.first, o.last},
            {62'd0, i == 0, i == DIM * DIM - 1});
      end
    end
  endtask

  typedef struct {
    logic          so;
    logic          push;
    logic [CW-1:0] x, y;
    logic [DW-1:0] d;
    logic          first, last;
  } vec_t;

  function automatic vec_t mk(input logic so, input logic push, input int x, input int y,
                              input int d, input logic first, input logic last);
    vec_t v;
    v.so = so; v.push = push; v.x = CW'(x); v.y = CW'(y);
    v.d = DW'(d); v.first = first; v.last = last;
    return v;
  endfunction

  vec_t tbl[9];
  wr_t  w;
  int   n;

  initial begin
    // drain vectors for a matrix of 300..324 starting held at (0,0)
    tbl[0] = mk(1, 1, 0, 0, 300, 1, 0);
    tbl[1] = mk(0, 1, 0, 0, 300, 1, 0);
    tbl[2] = mk(1, 1, 1, 0, 301, 0, 0);
    tbl[3] = mk(0, 1, 1, 0, 301, 0, 0);
    tbl[4] = mk(1, 1, 2, 0, 302, 0, 0);
    tbl[5] = mk(0, 1, 2, 0, 302, 0, 0);
    tbl[6] = mk(0, 1, 3, 0, 303, 0, 0);
    tbl[7] = mk(0, 1, 4, 0, 304, 0, 0);
    tbl[8] = mk(1, 1, 0, 1, 305, 0, 0);

    rst = 1'b0;
    bus.pushin = 1'b0; bus.firstin = 1'b0; bus.din = '0; bus.stopout = 1'b0;
`ifdef OUT_PINGPONG_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    stopin_seen = 1'b0;
    repeat (3) cyc();

    // reset state
    chk("rst stopin",   64'(bus.stopin),   0);
    chk("rst mwr",      64'(bus.mwr),      0);
    chk("rst pushout",  64'(bus.pushout),  0);
    chk("rst firstout", 64'(bus.firstout), 0);
    chk("rst lastout",  64'(bus.lastout),  0);
    chk("rst banks",    {62'd0, bus.mwbank, bus.mrbank}, 0);
    rst = 1'b1;
    cyc();

    // single matrix 0..24
    w_q.delete();
    stopin_seen = 1'b0;
    push_mat(0, 25, 1);
    cyc();
    chk("t1 write count", 64'(w_q.size()), 25);
    for (int i = 0; i < w_q.size() && i < 25; i++) begin
      w = w_q[i];
      chk($sformatf("t1 write[%0d]", i), {41'd0, w.bank, w.y, w.x, w.d[15:0]},
          {41'd0, 1'b0, 3'(i / 5), 3'(i % 5), 16'(i)});
    end
    check_out("t1", 0, 0);
    chk("t1 stopin stayed low", 64'(stopin_seen), 0);

    // two matrices, one idle cycle apart: second fill ends on the drain's last accept
    w_q.delete();
    stopin_seen = 1'b0;
    push_mat(0, 25, 1);
    cyc();
    push_mat(100, 25, 1);
    cyc();
    chk("t2 write count", 64'(w_q.size()), 50);
    for (int i = 0; i < w_q.size() && i < 50; i += 12) begin
      w = w_q[i];
      chk($sformatf("t2 write bank[%0d]", i), 64'(w.bank), (i < 25) ? 64'd1 : 64'd0);
    end
    check_out("t2a", 0, 0);
    check_out("t2b", 100, 0);
    chk("t2 stopin stayed low", 64'(stopin_seen), 0);

    // asynchronous reset in the middle of a fill
    bus.pushin = 1'b1; bus.firstin = 1'b1; bus.din = 900;
    cyc();
    bus.firstin = 1'b0;
    repeat (4) begin bus.din = bus.din + 1; cyc(); end
    chk("pre-rst mwr", 64'(bus.mwr), 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst mwr", 64'(bus.mwr), 0);
    chk("async rst mwxy", {58'd0, bus.mwy, bus.mwx}, 0);
    bus.pushin = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // both banks occupied while downstream stalls
    bus.stopout = 1'b1;
    stopin_seen = 1'b0;
    push_mat(300, 25, 1);
    push_mat(400, 25, 1);
    chk("t3 stopin low before full", 64'(stopin_seen), 0);
    chk("t3 stopin after last write", 64'(bus.stopin), 1);
    chk("t3 last write", {57'd0, bus.mwr, bus.mwbank, bus.mwy, bus.mwx}, {57'd0, 1'b1, 1'b1, 3'd4, 3'd4});
    bus.pushin = 1'b1; bus.firstin = 1'b1; bus.din = 999;
    repeat (3) begin
      cyc();
      chk("t3 dropped push mwr", 64'(bus.mwr), 0);
    end
    bus.pushin = 1'b0; bus.firstin = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t3 vec%0d pushout", k), 64'(bus.pushout), 64'(tbl[k].push));
      chk($sformatf("t3 vec%0d mrxy", k), {58'd0, bus.mry, bus.mrx}, {58'd0, tbl[k].y, tbl[k].x});
      chk($sformatf("t3 vec%0d dout", k), bus.dout, tbl[k].d);
      chk($sformatf("t3 vec%0d first/last", k), {62'd0, bus.firstout, bus.lastout},
          {62'd0, tbl[k].first, tbl[k].last});
      bus.stopout = tbl[k].so;
      cyc();
    end
    bus.stopout = 1'b0;
    n = 0;
    while (!(bus.pushout && bus.lastout && !bus.mrbank) && n < 200) begin
      cyc();
      n++;
    end
    chk("t3 bank0 last reached", 64'(n < 200), 1);
    chk("t3 stopin at bank0 last", 64'(bus.stopin), 1);
    cyc();
    chk("t3 stopin released", 64'(bus.stopin), 0);
    check_out("t3a", 300, 0);
    check_out("t3b", 400, 0);

    // firstin reasserted after 7 elements
    push_mat(500, 7, 1);
    bus.pushin = 1'b1; bus.firstin = 1'b1; bus.din = 600;
    cyc();
    chk("t5 restart write", {42'd0, bus.mwr, bus.mwy, bus.mwx, bus.mwd[14:0]}, {42'd0, 1'b1, 3'd0, 3'd0, 15'd600});
    push_mat(601, 24, 0);
    check_out("t5", 600, 0);

`ifdef OUT_PINGPONG_TRANSPOSE_EN
    transpose = 1'b1;
    push_mat(700, 25, 1);
    check_out("t6 transpose", 700, 1);
    transpose = 1'b0;
`endif

    repeat (5) cyc();
    chk("no extra outputs", 64'(out_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
